fifo_status_gen: RTL and testbench

- Status/flag stage for the 16-deep FIFO.
- Consumes the write and read pointers (ADDR_W+1 bits, MSB is the wrap bit) and the raw wr/rd requests.
- Produces fifo_full and fifo_empty, which gate the write- and read-pointer stages, plus occupancy, almost flags and sticky overflow/underflow error flags.
- Sits between the pointer stages and the top-level FIFO ports.

---
 rtl/fifo_status_gen.sv | 127 ++++++++++++
 tb/tb_fifo_status_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_status_gen.sv
// -----------------------------------------------------------------------------
// fifo_status_gen
//
// Status/flag stage for the FIFO. It turns the write and read pointers
// (ADDR_W+1 bits, MSB is the wrap bit) into the full/empty flags that gate the
// pointer stages. It also produces occupancy, the almost-full/almost-empty
// flags and the sticky overflow/underflow error flags.
//
// Full, empty, count and the almost flags are purely combinational from the
// pointers. The pointer stages therefore always see flags that match the
// pointer values of the current cycle.
//
// Optional feature macro: FIFO_PEAK_EN
//   defined   : fifo_peak is a high-water-mark register, max(peak, count), one
//               cycle behind occupancy. err_clr reloads it with the current
//               count, and the clear wins over the update.
//   undefined : fifo_peak is tied to 0 and no peak register is built.
//
// Ports:
//   clk               in   clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   wptr, rptr        in   write/read pointers [ADDR_W:0]
//   wr, rd            in   raw write/read requests from the FIFO user
//   err_clr           in   synchronous clear of the sticky error flags
//   fifo_full         out  2**ADDR_W entries held
//   fifo_empty        out  0 entries held
//   fifo_almost_full  out  count >= AFULL_THR
//   fifo_almost_empty out  count <= AEMPTY_THR
//   fifo_count        out  occupancy 0..2**ADDR_W
//   fifo_overflow     out  sticky: write attempted while full
//   fifo_underflow    out  sticky: read attempted while empty
//   fifo_peak         out  high-water mark (0 when FIFO_PEAK_EN is undefined)
// -----------------------------------------------------------------------------
module fifo_status_gen #(
   parameter int ADDR_W     = 4,
   parameter int AFULL_THR  = 14,
   parameter int AEMPTY_THR = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W:0]   wptr,
   input  logic [ADDR_W:0]   rptr,
   input  logic              wr,
   input  logic              rd,
   input  logic              err_clr,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              fifo_almost_full,
   output logic              fifo_almost_empty,
   output logic [ADDR_W:0]   fifo_count,
   output logic              fifo_overflow,
   output logic              fifo_underflow,
   output logic [ADDR_W:0]   fifo_peak
);

   // The thresholds are sized to the count width so that the compares are
   // width-matched. Both thresholds fit in ADDR_W+1 bits.
   localparam logic [ADDR_W:0] AFULL_C  = AFULL_THR[ADDR_W:0];
   localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_THR[ADDR_W:0];

   logic overflow_d,  overflow_q;
   logic underflow_d, underflow_q;
   logic ovf_evt, unf_evt;

   // Combinational flags, same cycle as the pointers.
   // The subtraction is modulo 2**(ADDR_W+1), so it stays correct across wrap.
   always_comb begin
      fifo_count        = wptr - rptr;
      fifo_empty        = (wptr == rptr);
      fifo_full         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                          (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
      fifo_almost_full  = (fifo_count >= AFULL_C);
      fifo_almost_empty = (fifo_count <= AEMPTY_C);
   end

   // Sticky error flags. A new event takes priority over err_clr in the
   // same cycle, so no error can be lost to a concurrent clear.
   always_comb begin
      ovf_evt     = wr & fifo_full;
      unf_evt     = rd & fifo_empty;
      overflow_d  = ovf_evt | (overflow_q  & ~err_clr);
      underflow_d = unf_evt | (underflow_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign fifo_overflow  = overflow_q;
   assign fifo_underflow = underflow_q;

`ifdef FIFO_PEAK_EN
   function automatic logic [ADDR_W:0] max_cnt(input logic [ADDR_W:0] a,
                                               input logic [ADDR_W:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [ADDR_W:0] peak_d, peak_q;

   // err_clr re-arms the high-water mark at the present occupancy.
   always_comb begin
      peak_d = max_cnt(peak_q, fifo_count);
      if (err_clr) begin
         peak_d = fifo_count;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign fifo_peak = peak_q;
`else
   assign fifo_peak = '0;
`endif

endmodule

// File: tb/tb_fifo_status_gen.sv
// -----------------------------------------------------------------------------
// tb_fifo_status_gen
//
// Directed testbench for fifo_status_gen with ADDR_W=4, AFULL_THR=14 and
// AEMPTY_THR=2. Inputs change on the falling edge. Combinational outputs are
// checked 1 ns after the inputs change. Registered outputs are checked 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_status_gen;

   localparam int ADDR_W = 4;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W:0]   wptr;
   logic [ADDR_W:0]   rptr;
   logic              wr;
   logic              rd;
   logic              err_clr;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_almost_full;
   logic              fifo_almost_empty;
   logic [ADDR_W:0]   fifo_count;
   logic              fifo_overflow;
   logic              fifo_underflow;
   logic [ADDR_W:0]   fifo_peak;

   int n_checks = 0;
   int n_errors = 0;

   fifo_status_gen #(
      .ADDR_W    (ADDR_W),
      .AFULL_THR (14),
      .AEMPTY_THR(2)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .wptr             (wptr),
      .rptr             (rptr),
      .wr               (wr),
      .rd               (rd),
      .err_clr          (err_clr),
      .fifo_full        (fifo_full),
      .fifo_empty       (fifo_empty),
      .fifo_almost_full (fifo_almost_full),
      .fifo_almost_empty(fifo_almost_empty),
      .fifo_count       (fifo_count),
      .fifo_overflow    (fifo_overflow),
      .fifo_underflow   (fifo_underflow),
      .fifo_peak        (fifo_peak)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Drive on the falling edge, away from the sampling edge.
   task automatic drive(input logic [ADDR_W:0] w, input logic [ADDR_W:0] r,
                        input logic wr_i, input logic rd_i, input logic clr_i);
      @(negedge clk);
      wptr    = w;
      rptr    = r;
      wr      = wr_i;
      rd      = rd_i;
      err_clr = clr_i;
      #1;
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      wptr    = '0;
      rptr    = '0;
      wr      = 1'b0;
      rd      = 1'b0;
      err_clr = 1'b0;
      #2;
      // Reset state
      check("rst_empty",  fifo_empty, 1);
      check("rst_full",   fifo_full, 0);
      check("rst_count",  fifo_count, 0);
      check("rst_aempty", fifo_almost_empty, 1);
      check("rst_afull",  fifo_almost_full, 0);
      check("rst_ovf",    fifo_overflow, 0);
      check("rst_unf",    fifo_underflow, 0);
      check("rst_peak",   fifo_peak, 0);

      @(negedge clk);
      rst_n = 1'b1;
      edge_sample();
      check("idle_empty", fifo_empty, 1);
      check("idle_ovf",   fifo_overflow, 0);

      // Fill ramp: wptr 0..16, rptr 0
      for (int i = 0; i <= 16; i++) begin
         drive(5'(i), 5'd0, 1'b0, 1'b0, 1'b0);
         check("ramp_count",  fifo_count, i);
         check("ramp_aempty", fifo_almost_empty, (i <= 2) ? 1 : 0);
         check("ramp_afull",  fifo_almost_full, (i >= 14) ? 1 : 0);
         check("ramp_full",   fifo_full, (i == 16) ? 1 : 0);
         check("ramp_empty",  fifo_empty, (i == 0) ? 1 : 0);
      end
      check("ramp_ovf_quiet", fifo_overflow, 0);

      // Occupancy across the pointer wrap
      drive(5'b00010, 5'b10110, 1'b0, 1'b0, 1'b0);
      check("wrap_count", fifo_count, 12);
      check("wrap_full",  fifo_full, 0);
      check("wrap_empty", fifo_empty, 0);
      check("wrap_afull", fifo_almost_full, 0);
      drive(5'b10110, 5'b10110, 1'b0, 1'b0, 1'b0);
      check("wrap_eq_empty", fifo_empty, 1);
      check("wrap_eq_count", fifo_count, 0);
      // Full with the lower bits equal but not zero
      drive(5'b00101, 5'b10101, 1'b0, 1'b0, 1'b0);
      check("full_nz_full",  fifo_full, 1);
      check("full_nz_count", fifo_count, 16);

      // Partly full, wr and rd together: no flag activity
      drive(5'd7, 5'd3, 1'b1, 1'b1, 1'b0);
      edge_sample();
      check("mid_wrrd_ovf", fifo_overflow, 0);
      check("mid_wrrd_unf", fifo_underflow, 0);

      // Full, wr and rd together: overflow only
      drive(5'b10000, 5'd0, 1'b1, 1'b1, 1'b0);
      check("ovf_pre", fifo_overflow, 0);
      edge_sample();
      check("ovf_set",    fifo_overflow, 1);
      check("ovf_no_unf", fifo_underflow, 0);
      drive(5'b10000, 5'd0, 1'b0, 1'b0, 1'b0);
      edge_sample();
      check("ovf_hold", fifo_overflow, 1);
      drive(5'b10000, 5'd0, 1'b0, 1'b0, 1'b1);
      check("ovf_before_clr", fifo_overflow, 1);
      edge_sample();
      check("ovf_clr", fifo_overflow, 0);
      // Set, then clear concurrent with a new overflow: set wins
      drive(5'b10000, 5'd0, 1'b1, 1'b0, 1'b0);
      edge_sample();
      check("ovf_reset", fifo_overflow, 1);
      drive(5'b10000, 5'd0, 1'b1, 1'b0, 1'b1);
      edge_sample();
      check("ovf_set_wins", fifo_overflow, 1);
      drive(5'b10000, 5'd0, 1'b0, 1'b0, 1'b1);
      edge_sample();
      check("ovf_clr2", fifo_overflow, 0);

      // Empty, wr and rd together: underflow only
      drive(5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
      edge_sample();
      check("unf_set",    fifo_underflow, 1);
      check("unf_no_ovf", fifo_overflow, 0);
      drive(5'd9, 5'd9, 1'b0, 1'b0, 1'b0);
      edge_sample();
      check("unf_hold", fifo_underflow, 1);

      // Asynchronous reset in the middle of the low phase
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_unf",  fifo_underflow, 0);
      check("async_peak", fifo_peak, 0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef FIFO_PEAK_EN
      // High-water mark: fill to 11, drain to 4, then re-arm
      drive(5'd11, 5'd0, 1'b0, 1'b0, 1'b0);
      check("peak_lag", fifo_peak, 0);
      edge_sample();
      check("peak_fill", fifo_peak, 11);
      drive(5'd11, 5'd7, 1'b0, 1'b0, 1'b0);
      edge_sample();
      check("peak_drain", fifo_peak, 11);
      drive(5'd11, 5'd7, 1'b0, 1'b0, 1'b1);
      edge_sample();
      check("peak_clr", fifo_peak, 4);
      drive(5'd11, 5'd5, 1'b0, 1'b0, 1'b0);
      edge_sample();
      check("peak_rise", fifo_peak, 6);
`else
      drive(5'd11, 5'd0, 1'b0, 1'b0, 1'b0);
      edge_sample();
      check("peak_off_fill", fifo_peak, 0);
      drive(5'd11, 5'd7, 1'b0, 1'b0, 1'b1);
      edge_sample();
      check("peak_off_clr", fifo_peak, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
